bp_fe_fetch_buffer: RTL
=======================

Name: bp_fe_fetch_buffer

Overview:
Downstream of the FE memory stage. Tracks the PC of every fetch the memory stage accepts through its fixed 2-cycle latency, pairs each PC with the returned response, and queues instruction/exception packets for the backend. Reports a miss (ITLB or I$) to the PC generator once, then drops younger responses until the frontend flushes. Issues fetch credit so the queue can never overflow.

Parameters:
vaddr_width_p, 39, virtual PC width
instr_width_p, 32, instruction width
fifo_els_p, 4, packet queue depth (>=3, power of two)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, synchronous, active-low
fetch_v_i  in  1  fetch accepted by memory stage this cycle (yumi & op==fetch)
fetch_vaddr_i  in  vaddr_width_p  PC of accepted fetch
poison_i  in  1  frontend flush; same signal driven to the memory stage poison
fetch_ready_o  out  1  credit: PC generator may issue a fetch this cycle
mem_resp_v_i  in  1  memory-stage response valid
instr_access_fault_i  in  1  response field
instr_page_fault_i  in  1  response field
itlb_miss_i  in  1  response field
icache_miss_i  in  1  response field
data_i  in  instr_width_p  response instruction
pkt_v_o  out  1  queue head valid
pkt_pc_o  out  vaddr_width_p  head PC
pkt_instr_o  out  instr_width_p  head instruction (0 for exception packets)
pkt_exc_o  out  2  head exception: 00 none, 01 access fault, 10 page fault
pkt_yumi_i  in  1  backend consumes head; only when pkt_v_o
miss_v_o  out  1  one-cycle miss report
miss_pc_o  out  vaddr_width_p  PC of missing fetch
miss_itlb_o  out  1  1=ITLB miss, 0=I$ miss

Behaviour:
- Reset (reset_n_i low at clk edge): queue empty, tracker stages invalid, state RUN. While reset_n_i low all outputs 0 (fetch_ready_o forced 0).
- Tracker: stage1 {v,pc} <= {fetch_v_i, fetch_vaddr_i}; stage2 <= stage1 & ~poison_i. mem_resp_v_i pairs with stage2 PC. poison_i clears stage1 and stage2 valids.
- Response with mem_resp_v_i and stage2 invalid: protocol error, simulation assertion; response ignored.
- States RUN, WAIT_FLUSH.
- RUN, response accepted (no poison_i same cycle), priority order:
  - access fault: enqueue {pc, 0, 01}; -> WAIT_FLUSH.
  - page fault: enqueue {pc, 0, 10}; -> WAIT_FLUSH.
  - itlb_miss: no enqueue; miss_v_o=1, miss_itlb_o=1, miss_pc_o=pc next cycle (registered); -> WAIT_FLUSH.
  - icache_miss: as itlb_miss with miss_itlb_o=0.
  - otherwise enqueue {pc, data_i, 00}.
- WAIT_FLUSH: all responses dropped, no enqueue, no miss report; poison_i -> RUN.
- miss_v_o is registered, high exactly one cycle, cleared by poison_i in the same cycle as its source response.
- poison_i (any state): empties queue, clears tracker, drops a same-cycle response, state -> RUN. Poison dominates concurrent enqueue, dequeue, fetch_v_i; fetch_v_i in the poison cycle is still captured into stage1 (new-path fetch).
- Credit: fetch_ready_o = (state==RUN) & ~poison_i & (count + stage1.v + stage2.v < fifo_els_p). Registered count only; dequeue in the current cycle does not add credit.
- Queue: circular, ptr width log2(fifo_els_p), wrap-around at fifo_els_p-1 -> 0. Enqueue and dequeue in the same cycle allowed at any occupancy including full. Enqueue while full without dequeue: assertion (unreachable under credit). pkt_yumi_i while empty: assertion, ignored.
- Head outputs are driven from storage (no bypass); enqueue in cycle t -> pkt_v_o at t+1.

Test Plan:
- Issue fetches PC 0x80000000, 0x80000004 back-to-back, clean responses at t+2, t+3 -> packets in order, pkt_exc_o=00, data matches; yumi held 1 -> queue empties.
- Hold pkt_yumi_i=0, issue continuously -> fetch_ready_o drops once count+inflight=4; exactly 4 packets queued, no overflow assertion.
- Response icache_miss=1 for PC 0x80000008 followed by clean response 0x8000000C -> miss_v_o pulses once with miss_pc_o=0x80000008, miss_itlb_o=0; 0x8000000C dropped; fetch_ready_o=0 until poison_i.
- Response with instr_page_fault=1 and itlb_miss=1 -> packet pkt_exc_o=10 enqueued, no miss_v_o; state WAIT_FLUSH.
- poison_i with 3 queued, 2 in flight, and a response in the same cycle -> queue empty next cycle, no packet, pkt_v_o=0, fetch_ready_o=1 next cycle.
- Assert reset_n_i low mid-stream with full queue -> all outputs 0 during reset; after release, queue empty, fetch_ready_o=1.

Source files
------------

// File: rtl/bp_fe_fetch_buffer_if.sv
// rtl/bp_fe_fetch_buffer_if.sv - packet handshake between fetch buffer and backend
//
// Purpose: carries the head-of-queue instruction/exception packet from the
// fetch buffer (master) to the backend consumer (slave).
// Signals:
//   pkt_v_o      head valid
//   pkt_pc_o     head PC
//   pkt_instr_o  head instruction (0 for exception packets)
//   pkt_exc_o    head exception: 00 none, 01 access fault, 10 page fault
//   pkt_yumi_i   backend consumes head (only while pkt_v_o)
interface bp_fe_fetch_buffer_if #(
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32
);
   logic                     pkt_v_o;
   logic [vaddr_width_p-1:0] pkt_pc_o;
   logic [instr_width_p-1:0] pkt_instr_o;
   logic [1:0]               pkt_exc_o;
   logic                     pkt_yumi_i;

   modport master (
      output pkt_v_o, pkt_pc_o, pkt_instr_o, pkt_exc_o,
      input  pkt_yumi_i
   );

   modport slave (
      input  pkt_v_o, pkt_pc_o, pkt_instr_o, pkt_exc_o,
      output pkt_yumi_i
   );
endinterface

// File: rtl/bp_fe_fetch_buffer.sv
// rtl/bp_fe_fetch_buffer.sv - FE fetch tracker, miss reporter and packet queue
//
// Purpose: follows every accepted fetch through the 2-cycle memory stage,
// pairs the response with its PC, queues instruction/exception packets,
// reports an ITLB/I$ miss once and then drops responses until poison_i.
// Ports:
//   clk_i, reset_n_i       clock, synchronous active-low reset
//   fetch_v_i/_vaddr_i     fetch accepted by the memory stage and its PC
//   poison_i               frontend flush
//   fetch_ready_o          fetch credit to the PC generator
//   mem_resp_v_i + fields  memory-stage response (faults, misses, data_i)
//   pkt_if (master)        head-of-queue packet and backend consume
//   miss_v_o/_pc_o/_itlb_o registered one-cycle miss report
module bp_fe_fetch_buffer #(
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32,
   parameter int fifo_els_p    = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     fetch_v_i,
   input  logic [vaddr_width_p-1:0] fetch_vaddr_i,
   input  logic                     poison_i,
   output logic                     fetch_ready_o,
   input  logic                     mem_resp_v_i,
   input  logic                     instr_access_fault_i,
   input  logic                     instr_page_fault_i,
   input  logic                     itlb_miss_i,
   input  logic                     icache_miss_i,
   input  logic [instr_width_p-1:0] data_i,
   bp_fe_fetch_buffer_if.master     pkt_if,
   output logic                     miss_v_o,
   output logic [vaddr_width_p-1:0] miss_pc_o,
   output logic                     miss_itlb_o
);

   localparam int ptr_w_lp = $clog2(fifo_els_p);
   localparam int cnt_w_lp = ptr_w_lp + 1;
   localparam int occ_w_lp = cnt_w_lp + 1;
   localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(fifo_els_p);
   localparam logic [occ_w_lp-1:0] els_lp  = occ_w_lp'(fifo_els_p);

   typedef enum logic {RUN, WAIT_FLUSH} state_e;

   state_e                   state_q, state_d;
   logic                     stage1_v_q, stage2_v_q;
   logic [vaddr_width_p-1:0] stage1_pc_q, stage2_pc_q;
   logic [ptr_w_lp-1:0]      wr_ptr_q, rd_ptr_q;
   logic [cnt_w_lp-1:0]      count_q;
   logic                     miss_v_q, miss_itlb_q;
   logic [vaddr_width_p-1:0] miss_pc_q;

   logic [vaddr_width_p-1:0] pc_mem_q    [fifo_els_p];
   logic [instr_width_p-1:0] instr_mem_q [fifo_els_p];
   logic [1:0]               exc_mem_q   [fifo_els_p];

   logic                     resp_ok, enq, deq, miss_d, miss_itlb_d;
   logic [instr_width_p-1:0] enq_instr;
   logic [1:0]               enq_exc;
   logic [occ_w_lp-1:0]      occ;

   always_comb begin
      // A response only counts in RUN with a tracked PC and no flush racing it.
      resp_ok     = mem_resp_v_i & stage2_v_q & ~poison_i & (state_q == RUN);
      enq         = 1'b0;
      enq_instr   = '0;
      enq_exc     = 2'b00;
      miss_d      = 1'b0;
      miss_itlb_d = 1'b0;
      state_d     = state_q;
      if (resp_ok) begin
         if (instr_access_fault_i) begin
            enq     = 1'b1;
            enq_exc = 2'b01;
            state_d = WAIT_FLUSH;
         end else if (instr_page_fault_i) begin
            enq     = 1'b1;
            enq_exc = 2'b10;
            state_d = WAIT_FLUSH;
         end else if (itlb_miss_i | icache_miss_i) begin
            miss_d      = 1'b1;
            miss_itlb_d = itlb_miss_i;
            state_d     = WAIT_FLUSH;
         end else begin
            enq       = 1'b1;
            enq_instr = data_i;
         end
      end
      if (poison_i) state_d = RUN;
      deq = pkt_if.pkt_yumi_i & (count_q != '0);
      // Credit reserves a slot for every fetch still in the memory stage.
      occ = occ_w_lp'(count_q) + occ_w_lp'(stage1_v_q) + occ_w_lp'(stage2_v_q);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= RUN;
         stage1_v_q  <= 1'b0;
         stage2_v_q  <= 1'b0;
         stage1_pc_q <= '0;
         stage2_pc_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         miss_v_q    <= 1'b0;
         miss_itlb_q <= 1'b0;
         miss_pc_q   <= '0;
      end else begin
         assert (!(mem_resp_v_i && !stage2_v_q));
         assert (!(enq && (count_q == full_lp) && !deq));
         assert (!(pkt_if.pkt_yumi_i && (count_q == '0)));
         state_q     <= state_d;
         // The poison-cycle fetch belongs to the new path, so stage1 always loads.
         stage1_v_q  <= fetch_v_i;
         stage1_pc_q <= fetch_vaddr_i;
         stage2_v_q  <= stage1_v_q & ~poison_i;
         stage2_pc_q <= stage1_pc_q;
         miss_v_q    <= miss_d;
         miss_itlb_q <= miss_itlb_d;
         if (miss_d) miss_pc_q <= stage2_pc_q;
         if (poison_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + ptr_w_lp'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + ptr_w_lp'(1);
            count_q <= count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) begin
         pc_mem_q[wr_ptr_q]    <= stage2_pc_q;
         instr_mem_q[wr_ptr_q] <= enq_instr;
         exc_mem_q[wr_ptr_q]   <= enq_exc;
      end
   end

   assign fetch_ready_o      = reset_n_i & (state_q == RUN) & ~poison_i & (occ < els_lp);
   assign pkt_if.pkt_v_o     = reset_n_i & (count_q != '0);
   assign pkt_if.pkt_pc_o    = reset_n_i ? pc_mem_q[rd_ptr_q]    : '0;
   assign pkt_if.pkt_instr_o = reset_n_i ? instr_mem_q[rd_ptr_q] : '0;
   assign pkt_if.pkt_exc_o   = reset_n_i ? exc_mem_q[rd_ptr_q]   : 2'b00;
   assign miss_v_o           = reset_n_i & miss_v_q;
   assign miss_pc_o          = reset_n_i ? miss_pc_q : '0;
   assign miss_itlb_o        = reset_n_i & miss_itlb_q;

endmodule
